// File: rtl/global_defs.sv
// Global sizing for the MPU datapath: element width, matrix bounds, index and
// register address widths shared by every MPU block.
package global_defs;
   localparam int FP              = 32;
   localparam int M               = 4;
   localparam int N               = 4;
   localparam int MBITS           = 2;
   localparam int NBITS           = 2;
   localparam int MATRIX_REG_SIZE = 3;
endpackage

// File: rtl/mpu_pkg.sv
// MPU sequencer types: FSM state encoding, largest legal last-index values
// and the command size check.
package mpu_pkg;
   import global_defs::*;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } seq_state_t;

   localparam logic [MBITS:0] M_LAST_MAX = (MBITS + 1)'(M - 1);
   localparam logic [NBITS:0] N_LAST_MAX = (NBITS + 1)'(N - 1);

   // Commands carry last indices (rows-1, cols-1), so the bound is M-1 / N-1.
   function automatic logic size_ok(input logic [MBITS:0] m_last,
                                    input logic [NBITS:0] n_last);
      return (m_last <= M_LAST_MAX) && (n_last <= N_LAST_MAX);
   endfunction
endpackage

// File: rtl/mpu_index_counter.sv
// Row-major i/j element counter; last is high while the counter sits on the
// final element (i == m_last && j == n_last).
module mpu_index_counter
   import global_defs::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step,
   input  logic [MBITS:0]   m_last,
   input  logic [NBITS:0]   n_last,
   output logic [MBITS:0]   i,
   output logic [NBITS:0]   j,
   output logic             last
);
   localparam logic [MBITS:0] I_ONE = {{MBITS{1'b0}}, 1'b1};
   localparam logic [NBITS:0] J_ONE = {{NBITS{1'b0}}, 1'b1};

   assign last = (i == m_last) && (j == n_last);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         i <= '0;
         j <= '0;
      end else if (step) begin
         if (j == n_last) begin
            j <= '0;
            i <= i + I_ONE;
         end else begin
            j <= j + J_ONE;
         end
      end
   end
endmodule

// File: rtl/mpu_matrix_sequencer.sv
// Streams a matrix from memory into one matrix register (LOAD) or from one
// register back out to memory (STORE), generating every row/column location.
module mpu_matrix_sequencer
   import global_defs::*;
   import mpu_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_load_in,
   input  logic                        cmd_store_in,
   input  logic [MATRIX_REG_SIZE-1:0]  cmd_addr_in,
   input  logic [MBITS:0]              cmd_m_last_in,
   input  logic [NBITS:0]              cmd_n_last_in,
   output logic                        cmd_ready_out,
   output logic                        cmd_err_out,
   input  logic                        ld_valid_in,
   input  logic [FP-1:0]               ld_element_in,
   output logic                        ld_ready_out,
   output logic                        ld_done_out,
   output logic                        st_valid_out,
   output logic [FP-1:0]               st_element_out,
   output logic                        st_last_out,
   input  logic                        st_ready_in,
   output logic                        st_done_out,
   output logic                        reg_load_en_out,
   output logic [MATRIX_REG_SIZE-1:0]  reg_load_addr_out,
   output logic [FP-1:0]               reg_load_element_out,
   output logic [MBITS:0]              reg_i_load_loc_out,
   output logic [NBITS:0]              reg_j_load_loc_out,
   output logic [MBITS:0]              reg_m_size_out,
   output logic [NBITS:0]              reg_n_size_out,
   output logic                        reg_store_en_out,
   output logic [MATRIX_REG_SIZE-1:0]  reg_store_addr_out,
   output logic [MBITS:0]              reg_i_store_loc_out,
   output logic [NBITS:0]              reg_j_store_loc_out,
   input  logic [FP-1:0]               reg_store_element_in,
   input  logic                        reg_store_complete_in,
   output logic                        seq_err_out
);
   seq_state_t                  state;
   logic [MATRIX_REG_SIZE-1:0]  addr_q;
   logic [MBITS:0]              m_last_q;
   logic [NBITS:0]              n_last_q;
   logic                        issue_pending;
   logic                        st_fresh;
   logic [FP-1:0]               st_hold;

   logic                        cmd_go;
   logic                        cmd_ok;
   logic                        cmd_take;
   logic                        ld_fire;
   logic                        st_fire;
   logic [MBITS:0]              ld_i;
   logic [NBITS:0]              ld_j;
   logic                        ld_last;
   logic [MBITS:0]              st_i;
   logic [NBITS:0]              st_j;
   logic                        st_last_loc;

   assign cmd_ready_out = (state == IDLE);
   assign ld_ready_out  = (state == LOAD);
   assign cmd_go        = cmd_ready_out && (cmd_load_in || cmd_store_in);
   assign cmd_ok        = size_ok(cmd_m_last_in, cmd_n_last_in);
   assign cmd_take      = cmd_go && cmd_ok;
   assign ld_fire       = ld_valid_in && ld_ready_out;
   assign st_fire       = st_valid_out && st_ready_in;

   // A read is only issued when the output slot is free or draining this cycle.
   assign reg_store_en_out    = (state == STORE) && issue_pending &&
                                (!st_valid_out || st_ready_in);
   assign reg_store_addr_out  = addr_q;
   assign reg_i_store_loc_out = st_i;
   assign reg_j_store_loc_out = st_j;

   // Read data arrives the cycle after issue; afterwards the captured copy holds the beat.
   assign st_element_out = st_fresh ? reg_store_element_in : st_hold;

   mpu_index_counter u_ld_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cmd_take),
      .step   (ld_fire),
      .m_last (m_last_q),
      .n_last (n_last_q),
      .i      (ld_i),
      .j      (ld_j),
      .last   (ld_last)
   );

   mpu_index_counter u_st_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cmd_take),
      .step   (reg_store_en_out),
      .m_last (m_last_q),
      .n_last (n_last_q),
      .i      (st_i),
      .j      (st_j),
      .last   (st_last_loc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         addr_q               <= '0;
         m_last_q             <= '0;
         n_last_q             <= '0;
         issue_pending        <= 1'b0;
         st_fresh             <= 1'b0;
         st_hold              <= '0;
         cmd_err_out          <= 1'b0;
         ld_done_out          <= 1'b0;
         st_valid_out         <= 1'b0;
         st_last_out          <= 1'b0;
         st_done_out          <= 1'b0;
         reg_load_en_out      <= 1'b0;
         reg_load_addr_out    <= '0;
         reg_load_element_out <= '0;
         reg_i_load_loc_out   <= '0;
         reg_j_load_loc_out   <= '0;
         reg_m_size_out       <= '0;
         reg_n_size_out       <= '0;
         seq_err_out          <= 1'b0;
      end else begin
         cmd_err_out     <= 1'b0;
         reg_load_en_out <= 1'b0;
         ld_done_out     <= 1'b0;
         st_done_out     <= 1'b0;
         st_fresh        <= reg_store_en_out;

         if (st_fresh) begin
            st_hold <= reg_store_element_in;
            if (st_last_out != reg_store_complete_in)
               seq_err_out <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cmd_go) begin
                  if (!cmd_ok) begin
                     cmd_err_out <= 1'b1;
                  end else begin
                     addr_q   <= cmd_addr_in;
                     m_last_q <= cmd_m_last_in;
                     n_last_q <= cmd_n_last_in;
                     // Load has priority; a simultaneous store request is dropped.
                     if (cmd_load_in) begin
                        state <= LOAD;
                     end else begin
                        state         <= STORE;
                        issue_pending <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               if (ld_fire) begin
                  reg_load_en_out      <= 1'b1;
                  reg_load_addr_out    <= addr_q;
                  reg_load_element_out <= ld_element_in;
                  reg_i_load_loc_out   <= ld_i;
                  reg_j_load_loc_out   <= ld_j;
                  reg_m_size_out       <= m_last_q;
                  reg_n_size_out       <= n_last_q;
                  if (ld_last) begin
                     ld_done_out <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            STORE: begin
               if (reg_store_en_out) begin
                  st_valid_out <= 1'b1;
                  st_last_out  <= st_last_loc;
                  if (st_last_loc)
                     issue_pending <= 1'b0;
               end else if (st_fire) begin
                  st_valid_out <= 1'b0;
               end
               if (st_fire && st_last_out) begin
                  st_valid_out <= 1'b0;
                  st_last_out  <= 1'b0;
                  st_done_out  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mpu_matrix_sequencer.sv
// Scoreboard bench for mpu_matrix_sequencer with a behavioural register file.
module tb_mpu_matrix_sequencer;
   import global_defs::*;

   logic                        clk;
   logic                        rst;
   logic                        cmd_load_in, cmd_store_in;
   logic [MATRIX_REG_SIZE-1:0]  cmd_addr_in;
   logic [MBITS:0]              cmd_m_last_in;
   logic [NBITS:0]              cmd_n_last_in;
   logic                        cmd_ready_out, cmd_err_out;
   logic                        ld_valid_in, ld_ready_out, ld_done_out;
   logic [FP-1:0]               ld_element_in;
   logic                        st_valid_out, st_last_out, st_ready_in, st_done_out;
   logic [FP-1:0]               st_element_out;
   logic                        reg_load_en_out;
   logic [MATRIX_REG_SIZE-1:0]  reg_load_addr_out;
   logic [FP-1:0]               reg_load_element_out;
   logic [MBITS:0]              reg_i_load_loc_out, reg_m_size_out;
   logic [NBITS:0]              reg_j_load_loc_out, reg_n_size_out;
   logic                        reg_store_en_out;
   logic [MATRIX_REG_SIZE-1:0]  reg_store_addr_out;
   logic [MBITS:0]              reg_i_store_loc_out;
   logic [NBITS:0]              reg_j_store_loc_out;
   logic [FP-1:0]               reg_store_element_in;
   logic                        reg_store_complete_in;
   logic                        seq_err_out;

   mpu_matrix_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_load_in(cmd_load_in), .cmd_store_in(cmd_store_in), .cmd_addr_in(cmd_addr_in),
      .cmd_m_last_in(cmd_m_last_in), .cmd_n_last_in(cmd_n_last_in),
      .cmd_ready_out(cmd_ready_out), .cmd_err_out(cmd_err_out),
      .ld_valid_in(ld_valid_in), .ld_element_in(ld_element_in), .ld_ready_out(ld_ready_out),
      .ld_done_out(ld_done_out),
      .st_valid_out(st_valid_out), .st_element_out(st_element_out), .st_last_out(st_last_out),
      .st_ready_in(st_ready_in), .st_done_out(st_done_out),
      .reg_load_en_out(reg_load_en_out), .reg_load_addr_out(reg_load_addr_out),
      .reg_load_element_out(reg_load_element_out),
      .reg_i_load_loc_out(reg_i_load_loc_out), .reg_j_load_loc_out(reg_j_load_loc_out),
      .reg_m_size_out(reg_m_size_out), .reg_n_size_out(reg_n_size_out),
      .reg_store_en_out(reg_store_en_out), .reg_store_addr_out(reg_store_addr_out),
      .reg_i_store_loc_out(reg_i_store_loc_out), .reg_j_store_loc_out(reg_j_store_loc_out),
      .reg_store_element_in(reg_store_element_in),
      .reg_store_complete_in(reg_store_complete_in),
      .seq_err_out(seq_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  addr;
      logic [2:0]  i;
      logic [2:0]  j;
      logic [31:0] elem;
      logic [2:0]  msz;
      logic [2:0]  nsz;
      logic        done;
   } ld_exp_t;

   typedef struct {
      logic [31:0] elem;
      logic        last;
   } st_exp_t;

   ld_exp_t      ld_q[$];
   st_exp_t      st_q[$];
   logic [31:0]  ld_data[$];

   int checks = 0;
   int failures = 0;
   int ld_en_cnt = 0, st_en_cnt = 0, ld_done_cnt = 0, st_done_cnt = 0;
   int cyc = 0, beat_first = -1, beat_last = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Behavioural register file: one-cycle read latency, end-of-matrix from stored sizes.
   logic [31:0] mem [0:7][0:3][0:3];
   logic [2:0]  msz_m [0:7];
   logic [2:0]  nsz_m [0:7];
   logic [31:0] rf_data = '0;
   logic        rf_comp = 1'b0;
   assign reg_store_element_in  = rf_data;
   assign reg_store_complete_in = rf_comp;

   always @(posedge clk) begin
      if (reg_load_en_out) begin
         mem[reg_load_addr_out][reg_i_load_loc_out[1:0]][reg_j_load_loc_out[1:0]] <= reg_load_element_out;
         msz_m[reg_load_addr_out] <= reg_m_size_out;
         nsz_m[reg_load_addr_out] <= reg_n_size_out;
      end
      if (reg_store_en_out) begin
         rf_data <= mem[reg_store_addr_out][reg_i_store_loc_out[1:0]][reg_j_store_loc_out[1:0]];
         rf_comp <= (reg_i_store_loc_out == msz_m[reg_store_addr_out]) &&
                    (reg_j_store_loc_out == nsz_m[reg_store_addr_out]);
      end
   end

   // Monitor: pops expectations whenever the DUT presents a load write or a store beat.
   initial begin : monitor
      ld_exp_t     le;
      st_exp_t     se;
      logic        prev_stall;
      logic [31:0] prev_elem;
      prev_stall = 1'b0;
      prev_elem  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reg_load_en_out) begin
            ld_en_cnt++;
            if (ld_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_load actual=%h required=none", reg_load_element_out);
            end else begin
               le = ld_q.pop_front();
               chk("ld_addr", reg_load_addr_out, le.addr);
               chk("ld_i", reg_i_load_loc_out, le.i);
               chk("ld_j", reg_j_load_loc_out, le.j);
               chk("ld_elem", reg_load_element_out, le.elem);
               chk("ld_msize", reg_m_size_out, le.msz);
               chk("ld_nsize", reg_n_size_out, le.nsz);
               chk("ld_done_at_en", ld_done_out, le.done);
            end
         end
         if (ld_done_out) begin
            ld_done_cnt++;
            chk("ld_done_with_en", reg_load_en_out, 1);
         end
         if (st_done_out) st_done_cnt++;
         if (reg_store_en_out) st_en_cnt++;
         if (prev_stall) begin
            chk("st_stall_valid", st_valid_out, 1);
            chk("st_stall_elem", st_element_out, prev_elem);
         end
         if (st_valid_out && !st_ready_in)
            chk("st_en_suppressed", reg_store_en_out, 0);
         if (st_valid_out && st_ready_in) begin
            if (beat_first < 0) beat_first = cyc;
            beat_last = cyc;
            if (st_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_st_beat actual=%h required=none", st_element_out);
            end else begin
               se = st_q.pop_front();
               chk("st_elem", st_element_out, se.elem);
               chk("st_last", st_last_out, se.last);
            end
         end
         prev_stall = st_valid_out && !st_ready_in;
         prev_elem  = st_element_out;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready_out, 1);
      chk({tag, "_cmd_err"}, cmd_err_out, 0);
      chk({tag, "_ld_ready"}, ld_ready_out, 0);
      chk({tag, "_ld_done"}, ld_done_out, 0);
      chk({tag, "_st_valid"}, st_valid_out, 0);
      chk({tag, "_st_elem"}, st_element_out, 0);
      chk({tag, "_st_last"}, st_last_out, 0);
      chk({tag, "_st_done"}, st_done_out, 0);
      chk({tag, "_rl_en"}, reg_load_en_out, 0);
      chk({tag, "_rl_addr"}, reg_load_addr_out, 0);
      chk({tag, "_rl_elem"}, reg_load_element_out, 0);
      chk({tag, "_rl_ij"}, {reg_i_load_loc_out, reg_j_load_loc_out}, 0);
      chk({tag, "_rl_size"}, {reg_m_size_out, reg_n_size_out}, 0);
      chk({tag, "_rs_en"}, reg_store_en_out, 0);
      chk({tag, "_rs_loc"}, {reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out}, 0);
      chk({tag, "_seq_err"}, seq_err_out, 0);
   endtask

   task automatic send_cmd(input logic ld, input logic st, input logic [2:0] a,
                           input logic [2:0] m, input logic [2:0] n);
      cmd_load_in   = ld;
      cmd_store_in  = st;
      cmd_addr_in   = a;
      cmd_m_last_in = m;
      cmd_n_last_in = n;
      @(posedge clk); #1;
      cmd_load_in  = 1'b0;
      cmd_store_in = 1'b0;
   endtask

   // Drives up to stop_after elements of ld_data; a partial run leaves ld_valid_in high.
   task automatic run_load(input logic [2:0] a, input logic [2:0] m, input logic [2:0] n,
                           input int stop_after, input logic with_store);
      int total, k, guard;
      logic hs;
      total = (m + 1) * (n + 1);
      for (int e = 0; e < stop_after; e++)
         ld_q.push_back('{addr: a, i: 3'(e / (n + 1)), j: 3'(e % (n + 1)),
                          elem: ld_data[e], msz: m, nsz: n, done: (e == total - 1)});
      send_cmd(1'b1, with_store, a, m, n);
      k = 0;
      guard = 0;
      while (k < stop_after && guard < 200) begin
         ld_valid_in   = 1'b1;
         ld_element_in = ld_data[k];
         @(negedge clk);
         hs = ld_ready_out;
         @(posedge clk); #1;
         if (hs) k++;
         guard++;
      end
      if (k < stop_after) begin
         checks++;
         failures++;
         $display("FAIL load_timeout actual=%0d required=%0d", k, stop_after);
      end
      if (stop_after == total) begin
         ld_valid_in = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   task automatic run_store(input logic [2:0] a, input logic [2:0] m, input logic [2:0] n,
                            input logic toggle);
      int total, c, start;
      logic pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      total = (m + 1) * (n + 1);
      for (int e = 0; e < total; e++)
         st_q.push_back('{elem: ld_data[e], last: (e == total - 1)});
      beat_first = -1;
      start = st_done_cnt;
      st_ready_in = 1'b1;
      send_cmd(1'b0, 1'b1, a, m, n);
      c = 0;
      while (st_done_cnt == start && c < 300) begin
         st_ready_in = toggle ? pat[c % 4] : 1'b1;
         @(posedge clk); #1;
         c++;
      end
      st_ready_in = 1'b1;
      chk("st_done_seen", st_done_cnt - start, 1);
      chk("st_q_drained", st_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int ld0, en0, st0;
      rst = 1'b1;
      cmd_load_in = 1'b0; cmd_store_in = 1'b0; cmd_addr_in = '0;
      cmd_m_last_in = '0; cmd_n_last_in = '0;
      ld_valid_in = 1'b0; ld_element_in = '0; st_ready_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // 2x3 load of 1.0..6.0 into reg 1, then stream it back out
      ld_data = '{32'h3F800000, 32'h40000000, 32'h40400000,
                  32'h40800000, 32'h40A00000, 32'h40C00000};
      ld0 = ld_done_cnt;
      run_load(3'd1, 3'd1, 3'd2, 6, 1'b0);
      chk("load1_done_cnt", ld_done_cnt - ld0, 1);
      chk("load1_q_drained", ld_q.size(), 0);
      chk("load1_idle", cmd_ready_out, 1);

      run_store(3'd1, 3'd1, 3'd2, 1'b0);
      chk("store1_consecutive", beat_last - beat_first, 5);
      chk("store1_seq_err", seq_err_out, 0);

      run_store(3'd1, 3'd1, 3'd2, 1'b1);

      // Simultaneous requests: load wins, store must be reissued
      ld_data = '{32'h11111111, 32'h22222222};
      st0 = st_en_cnt;
      run_load(3'd2, 3'd0, 3'd1, 2, 1'b1);
      chk("both_no_store_issue", st_en_cnt - st0, 0);
      chk("both_ld_q_drained", ld_q.size(), 0);
      run_store(3'd2, 3'd0, 3'd1, 1'b0);

      // 1x1 matrix
      ld_data = '{32'hDEADBEEF};
      run_load(3'd3, 3'd0, 3'd0, 1, 1'b0);
      run_store(3'd3, 3'd0, 3'd0, 1'b1);

      // Out-of-range commands are rejected
      en0 = ld_en_cnt;
      st0 = st_en_cnt;
      cmd_load_in = 1'b1; cmd_addr_in = 3'd5; cmd_m_last_in = 3'd4; cmd_n_last_in = 3'd0;
      @(posedge clk); #1;
      cmd_load_in = 1'b0;
      chk("err_m_pulse", cmd_err_out, 1);
      chk("err_m_ready", cmd_ready_out, 1);
      chk("err_m_ld_ready", ld_ready_out, 0);
      @(posedge clk); #1;
      chk("err_m_one_cycle", cmd_err_out, 0);
      cmd_store_in = 1'b1; cmd_m_last_in = 3'd0; cmd_n_last_in = 3'd4;
      @(posedge clk); #1;
      cmd_store_in = 1'b0;
      chk("err_n_pulse", cmd_err_out, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_no_load_en", ld_en_cnt - en0, 0);
      chk("err_no_store_en", st_en_cnt - st0, 0);
      chk("err_still_idle", cmd_ready_out, 1);

      // Reset after 3 of 6 load beats
      ld_data = '{32'hA0000001, 32'hA0000002, 32'hA0000003,
                  32'hA0000004, 32'hA0000005, 32'hA0000006};
      ld0 = ld_done_cnt;
      run_load(3'd4, 3'd1, 3'd2, 3, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      ld_valid_in = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_done", ld_done_cnt - ld0, 0);
      chk("abort_ld_q_drained", ld_q.size(), 0);

      ld_data = '{32'h3F800000, 32'h40000000, 32'h40400000,
                  32'h40800000, 32'h40A00000, 32'h40C00000};
      run_store(3'd1, 3'd1, 3'd2, 1'b0);

      chk("final_seq_err", seq_err_out, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
